mult_div_unit: RTL and testbench

Iterative multiply/divide unit (MDU) for MULT, MULTU, DIV and DIVU, holding the architectural HI/LO registers.
- Operands come from the register file read ports (rdat1 -> opa, rdat2 -> opb).
- hi/lo are read by MFHI/MFLO and written back through the register file write port.
- Sits beside the ALU in the execute stage; the control unit stalls the PC while busy=1.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mult_div_unit_if.sv | 33 +++
 rtl/mdu_step.sv | 34 +++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, MDU operation/state encodings and counter width.
package cpu_types_pkg;

    localparam int WORD_W    = 32;
    localparam int MDU_CNT_W = $clog2(WORD_W);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle of multiply/divide unit signals; mdu side drives results, tb/execute side drives requests.
interface mult_div_unit_if
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic CLK
);
    logic              nRST;
    logic              start;
    mdu_op_t           op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              flush;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdat;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport mdu (
        input  CLK, nRST, start, op, opa, opb, flush, hi_we, lo_we, wdat,
        output busy, done, div_zero, hi, lo
    );

    modport tb (
        input  CLK, busy, done, div_zero, hi, lo,
        output nRST, start, op, opa, opb, flush, hi_we, lo_we, wdat
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mdu_op_t             op,
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] acc_nxt
);
    logic              is_div;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh_rem;
    logic [DATA_W:0]   diff;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend/quotient in the low half and shifts left.
    always_comb begin
        is_div  = (op == DIV) || (op == DIVU);
        sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : '0);
        sh_rem  = acc[2*DATA_W-1:DATA_W-1];
        diff    = sh_rem - {1'b0, b};
        acc_nxt = {sum, acc[DATA_W-1:1]};
        if (is_div) begin
            if (diff[DATA_W]) begin
                acc_nxt = {sh_rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            end else begin
                acc_nxt = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; DATA_W+2 cycles start-to-done.
// Divide by zero completes in one cycle; flush aborts without touching HI/LO.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  mdu_op_t           op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mdu_state_t          state, state_nxt;
    mdu_op_t             op_q;
    logic [2*DATA_W-1:0] acc, acc_step, prod;
    logic [DATA_W-1:0]   b_q, abs_a, abs_b, quo, rem, fix_hi, fix_lo;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q, neg_r;
    logic                is_div_in, is_signed_in, zero_div, last_iter;
    logic                load_op, dz_accept, iter_en, fix_en;

    assign is_div_in    = (op == DIV) || (op == DIVU);
    assign is_signed_in = (op == MULT) || (op == DIV);
    assign zero_div     = is_div_in && (opb == '0);
    assign last_iter    = (cnt == CNT_W'(DATA_W - 1));
    assign abs_a        = (is_signed_in && opa[DATA_W-1]) ? -opa : opa;
    assign abs_b        = (is_signed_in && opb[DATA_W-1]) ? -opb : opb;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !flush && !zero_div) state_nxt = ITER;
            ITER: begin
                if (flush)          state_nxt = IDLE;
                else if (last_iter) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        load_op   = 1'b0;
        dz_accept = 1'b0;
        iter_en   = 1'b0;
        fix_en    = 1'b0;
        case (state)
            IDLE: begin
                load_op   = start && !flush && !zero_div;
                dz_accept = start && !flush && zero_div;
            end
            ITER: begin
                busy    = 1'b1;
                iter_en = !flush;
            end
            FIX: begin
                busy   = 1'b1;
                fix_en = !flush;
            end
            default: busy = 1'b0;
        endcase
    end

    mdu_step #(.DATA_W(DATA_W)) u_step (
        .op      (op_q),
        .acc     (acc),
        .b       (b_q),
        .acc_nxt (acc_step)
    );

    // Sign correction: the whole 2W product is negated together, while the
    // divide remainder follows the dividend sign independently of the quotient.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem    = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        fix_hi = prod[2*DATA_W-1:DATA_W];
        fix_lo = prod[DATA_W-1:0];
        if (op_q == DIV || op_q == DIVU) begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            op_q     <= MULT;
            acc      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= fix_en || dz_accept;
            div_zero <= dz_accept;
            if (load_op) begin
                op_q  <= op;
                acc   <= is_div_in ? {{DATA_W{1'b0}}, abs_a} : {{DATA_W{1'b0}}, abs_b};
                b_q   <= is_div_in ? abs_b : abs_a;
                cnt   <= '0;
                neg_q <= is_signed_in && (opa[DATA_W-1] ^ opb[DATA_W-1]);
                neg_r <= is_signed_in && opa[DATA_W-1];
            end else if (iter_en) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
            end
            if (fix_en) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (dz_accept) begin
                hi <= opa;
                lo <= '1;
            end else if (!busy) begin
                if (hi_we) hi <= wdat;
                if (lo_we) lo <= wdat;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed expected results.
module tb_mult_div_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST, start, flush, hi_we, lo_we;
    mdu_op_t     op;
    logic [31:0] opa, opb, wdat;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    mult_div_unit #(.DATA_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdat     (wdat),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int i;
        i = 0;
        while (!done && i < max_cyc) begin
            step(1);
            i++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic saw_done;
        nRST = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = MULT; opa = '0; opb = '0; wdat = '0;
        step(2);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        nRST = 1'b1;
        step(1);

        // MULTU max x max with exact cycle timing
        start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mu_busy_n1", busy, 1);
        step(32);
        check("mu_busy_n33", busy, 1);
        check("mu_done_n33", done, 0);
        step(1);
        check("mu_done_n34", done, 1);
        check("mu_busy_n34", busy, 0);
        check("mu_hi", hi, 32'hFFFF_FFFE);
        check("mu_lo", lo, 32'h0000_0001);
        step(1);
        check("mu_done_pulse", done, 0);

        // signed multiply
        start_op(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(40);
        check("m_hi", hi, 32'hFFFF_FFFF);
        check("m_lo", lo, 32'hFFFF_FFF1);
        step(1);

        // signed divide
        start_op(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(40);
        check("d_lo", lo, 32'hFFFF_FFFD);
        check("d_hi", hi, 32'hFFFF_FFFF);
        check("d_dz", div_zero, 0);
        step(1);

        // signed overflow
        start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_dz", div_zero, 0);
        step(1);

        // divide by zero
        start_op(DIVU, 32'd7, 32'd0);
        check("dz_done", done, 1);
        check("dz_flag", div_zero, 1);
        check("dz_busy", busy, 0);
        check("dz_hi", hi, 32'd7);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        step(1);
        check("dz_pulse", done, 0);

        // MTHI, then a flushed MULTU, then a restarted MULTU
        hi_we = 1'b1; wdat = 32'h1234;
        step(1);
        hi_we = 1'b0;
        check("mthi", hi, 32'h1234);
        start_op(MULTU, 32'd3, 32'd4);
        saw_done = done;
        for (int i = 0; i < 9; i++) begin
            step(1);
            saw_done = saw_done | done;
        end
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        saw_done = saw_done | done;
        check("fl_busy", busy, 0);
        check("fl_hi", hi, 32'h1234);
        check("fl_nodone", saw_done, 0);
        start_op(MULTU, 32'd3, 32'd4);
        step(33);
        check("re_done", done, 1);
        check("re_hi", hi, 32'd0);
        check("re_lo", lo, 32'd12);
        step(1);

        // start and MTHI/MTLO while busy are ignored; start in the done cycle is taken
        start_op(MULTU, 32'd6, 32'd7);
        step(4);
        op = DIV; opa = 32'd100; opb = 32'd3; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdat = 32'hDEAD;
        step(1);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("bz_hi_kept", hi, 32'd0);
        step(28);
        check("bz_done", done, 1);
        check("bz_hi", hi, 32'd0);
        check("bz_lo", lo, 32'd42);
        start_op(MULTU, 32'd2, 32'd3);
        check("dc_busy", busy, 1);
        wait_done(40);
        check("dc_lo", lo, 32'd6);
        step(1);

        // flush and start together in IDLE: start dropped
        flush = 1'b1;
        start_op(MULTU, 32'd5, 32'd5);
        flush = 1'b0;
        check("fs_busy", busy, 0);
        step(1);
        check("fs_done", done, 0);
        check("fs_lo", lo, 32'd6);

        // reset mid-operation
        start_op(DIVU, 32'd100, 32'd7);
        step(4);
        nRST = 1'b0;
        step(1);
        check("mr_hi", hi, 0);
        check("mr_lo", lo, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        nRST = 1'b1;
        step(2);
        check("mr_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
